// File: rtl/gpio_cmd_decoder.sv
// Decodes MicroBlaze GPIO command words into modem datapath controls and drives the gpi0 read-back.
// Build option: define GPIO_CMD_BER_SNAPSHOT_EN to read all BER counters from one coherent snapshot.
module gpio_cmd_decoder #(
    parameter int NB_GPIOS        = 32,
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int MEM_RD_LAT      = 1
) (
    input  logic                       clk100,
    input  logic                       i_resetn,
    input  logic [NB_GPIOS-1:0]        gpo0,
    output logic [NB_GPIOS-1:0]        gpi0,
    output logic                       o_rst,
    output logic                       o_enb_tx,
    output logic                       o_enb_rx,
    output logic [1:0]                 o_phase_sel,
    output logic                       o_run_log,
    output logic                       o_read_log,
    output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log,
    input  logic                       i_mem_full,
    input  logic [BRAM_DATA_WIDTH-1:0] i_data_log,
    input  logic [63:0]                i_ber_samp_i,
    input  logic [63:0]                i_ber_samp_q,
    input  logic [63:0]                i_ber_err_i,
    input  logic [63:0]                i_ber_err_q
);
    localparam int PL_W = BRAM_ADDR_WIDTH;
    localparam logic [2:0] RD_LAT_C = 3'(MEM_RD_LAT);

    localparam logic [7:0] OP_RESET    = 8'd0;
    localparam logic [7:0] OP_EN_TX    = 8'd1;
    localparam logic [7:0] OP_EN_RX    = 8'd2;
    localparam logic [7:0] OP_PH_SEL   = 8'd3;
    localparam logic [7:0] OP_RUN_MEM  = 8'd4;
    localparam logic [7:0] OP_READ_MEM = 8'd5;
    localparam logic [7:0] OP_ADDR_MEM = 8'd6;
    localparam logic [7:0] OP_BER_S_I  = 8'd7;
    localparam logic [7:0] OP_BER_S_Q  = 8'd8;
    localparam logic [7:0] OP_BER_E_I  = 8'd9;
    localparam logic [7:0] OP_BER_E_Q  = 8'd10;
    localparam logic [7:0] OP_BER_H    = 8'd11;
    localparam logic [7:0] OP_MEM_FULL = 8'd12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t          state_r;
    logic [2:0]      wait_cnt_r;
    logic            en_d_r;
    logic            cmd_vld_r;
    logic [7:0]      cmd_op_r;
    logic [PL_W-1:0] cmd_pl_r;
    logic            pend_vld_r;
    logic [7:0]      pend_op_r;
    logic [PL_W-1:0] pend_pl_r;
    logic [31:0]     hi_shadow_r;

    logic            fire_s;
    logic            exec_vld_s;
    logic [7:0]      exec_op_s;
    logic [PL_W-1:0] exec_pl_s;
    logic [63:0]     ber_word_s;

    // Rising-edge detect and selection of the command to execute (pending slot has priority).
    always_comb begin
        fire_s     = gpo0[23] & ~en_d_r;
        exec_vld_s = (state_r == ST_IDLE) && (pend_vld_r || cmd_vld_r);
        if (pend_vld_r) begin
            exec_op_s = pend_op_r;
            exec_pl_s = pend_pl_r;
        end else begin
            exec_op_s = cmd_op_r;
            exec_pl_s = cmd_pl_r;
        end
    end

`ifdef GPIO_CMD_BER_SNAPSHOT_EN
    logic [63:0] snap_samp_q_r;
    logic [63:0] snap_err_i_r;
    logic [63:0] snap_err_q_r;

    // Snapshot bank: BER_S_I freezes the other three counters alongside the live samp_i read.
    always_ff @(posedge clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            snap_samp_q_r <= 64'd0;
            snap_err_i_r  <= 64'd0;
            snap_err_q_r  <= 64'd0;
        end else if (exec_vld_s && (exec_op_s == OP_BER_S_I)) begin
            snap_samp_q_r <= i_ber_samp_q;
            snap_err_i_r  <= i_ber_err_i;
            snap_err_q_r  <= i_ber_err_q;
        end
    end

    // Counter word selection from the snapshot bank.
    always_comb begin
        case (exec_op_s)
            OP_BER_S_Q: ber_word_s = snap_samp_q_r;
            OP_BER_E_I: ber_word_s = snap_err_i_r;
            OP_BER_E_Q: ber_word_s = snap_err_q_r;
            default:    ber_word_s = i_ber_samp_i;
        endcase
    end
`else
    // Counter word selection straight from the live counters.
    always_comb begin
        case (exec_op_s)
            OP_BER_S_Q: ber_word_s = i_ber_samp_q;
            OP_BER_E_I: ber_word_s = i_ber_err_i;
            OP_BER_E_Q: ber_word_s = i_ber_err_q;
            default:    ber_word_s = i_ber_samp_i;
        endcase
    end
`endif

    // Front end: previous enable level and the captured command of the firing cycle.
    always_ff @(posedge clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            en_d_r    <= 1'b0;
            cmd_vld_r <= 1'b0;
            cmd_op_r  <= 8'd0;
            cmd_pl_r  <= {PL_W{1'b0}};
        end else begin
            en_d_r    <= gpo0[23];
            cmd_vld_r <= fire_s;
            if (fire_s) begin
                cmd_op_r <= gpo0[31:24];
                cmd_pl_r <= gpo0[PL_W-1:0];
            end
        end
    end

    // One-deep pending slot: filled while busy, drained on the first idle cycle.
    always_ff @(posedge clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            pend_vld_r <= 1'b0;
            pend_op_r  <= 8'd0;
            pend_pl_r  <= {PL_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            // When the slot drains, a command arriving in the same cycle queues behind it.
            pend_vld_r <= pend_vld_r & cmd_vld_r;
            if (cmd_vld_r) begin
                pend_op_r <= cmd_op_r;
                pend_pl_r <= cmd_pl_r;
            end
        end else if (cmd_vld_r && !pend_vld_r) begin
            pend_vld_r <= 1'b1;
            pend_op_r  <= cmd_op_r;
            pend_pl_r  <= cmd_pl_r;
        end
    end

    // Command execution, memory read sequencer and all registered outputs.
    always_ff @(posedge clk100 or negedge i_resetn) begin
        if (!i_resetn) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 3'd0;
            hi_shadow_r <= 32'd0;
            gpi0        <= {NB_GPIOS{1'b0}};
            o_rst       <= 1'b1;
            o_enb_tx    <= 1'b0;
            o_enb_rx    <= 1'b0;
            o_phase_sel <= 2'd0;
            o_run_log   <= 1'b0;
            o_read_log  <= 1'b0;
            o_addr_log  <= {BRAM_ADDR_WIDTH{1'b0}};
        end else begin
            o_run_log <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (exec_vld_s) begin
                        case (exec_op_s)
                            OP_RESET:    o_rst       <= exec_pl_s[0];
                            OP_EN_TX:    o_enb_tx    <= exec_pl_s[0];
                            OP_EN_RX:    o_enb_rx    <= exec_pl_s[0];
                            OP_PH_SEL:   o_phase_sel <= exec_pl_s[1:0];
                            OP_RUN_MEM:  o_run_log   <= 1'b1;
                            OP_READ_MEM: o_read_log  <= exec_pl_s[0];
                            OP_ADDR_MEM: begin
                                o_addr_log <= exec_pl_s[BRAM_ADDR_WIDTH-1:0];
                                wait_cnt_r <= RD_LAT_C;
                                state_r    <= ST_WAIT;
                            end
                            OP_BER_S_I, OP_BER_S_Q, OP_BER_E_I, OP_BER_E_Q: begin
                                gpi0        <= NB_GPIOS'(ber_word_s[31:0]);
                                hi_shadow_r <= ber_word_s[63:32];
                            end
                            OP_BER_H:    gpi0 <= NB_GPIOS'(hi_shadow_r);
                            OP_MEM_FULL: gpi0 <= NB_GPIOS'(i_mem_full);
                            default: begin
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    wait_cnt_r <= wait_cnt_r - 3'd1;
                    if (wait_cnt_r == 3'd1) begin
                        state_r <= ST_CAPTURE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_CAPTURE: begin
                    gpi0    <= NB_GPIOS'(i_data_log);
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_cmd_decoder.sv
// Self-checking bench for gpio_cmd_decoder: table of command vectors plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_gpio_cmd_decoder;
    localparam int NV = 20;

    logic        clk100 = 1'b0;
    logic        i_resetn;
    logic [31:0] gpo0;
    logic [31:0] gpi0;
    logic        o_rst, o_enb_tx, o_enb_rx, o_run_log, o_read_log;
    logic [1:0]  o_phase_sel;
    logic [14:0] o_addr_log;
    logic        i_mem_full;
    logic [15:0] i_data_log;
    logic [15:0] mem_p1;
    logic [63:0] samp_i, samp_q, err_i, err_q;
    logic [53:0] dut_outs;

    gpio_cmd_decoder #(
        .NB_GPIOS(32), .BRAM_ADDR_WIDTH(15), .BRAM_DATA_WIDTH(16), .MEM_RD_LAT(2)
    ) dut (
        .clk100(clk100), .i_resetn(i_resetn), .gpo0(gpo0), .gpi0(gpi0),
        .o_rst(o_rst), .o_enb_tx(o_enb_tx), .o_enb_rx(o_enb_rx),
        .o_phase_sel(o_phase_sel), .o_run_log(o_run_log), .o_read_log(o_read_log),
        .o_addr_log(o_addr_log), .i_mem_full(i_mem_full), .i_data_log(i_data_log),
        .i_ber_samp_i(samp_i), .i_ber_samp_q(samp_q),
        .i_ber_err_i(err_i), .i_ber_err_q(err_q)
    );

    always #5 clk100 = ~clk100;

    // Two-stage BRAM read model; one address holds the pattern, the rest return their address.
    always @(posedge clk100) begin
        mem_p1     <= (o_addr_log == 15'h2F56) ? 16'hAF0F : {1'b0, o_addr_log};
        i_data_log <= mem_p1;
    end

    assign dut_outs = {gpi0, o_rst, o_enb_tx, o_enb_rx, o_phase_sel, o_run_log, o_read_log, o_addr_log};

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [22:0] pl;
        logic [53:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [53:0] exp;
    } sb_t;

    vec_t        tbl[NV];
    sb_t         sb_q[$];
    sb_t         e;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        cnt_run = 1'b0;
    logic [63:0] cnt_val = 64'd0;
    logic [63:0] sc, dl, exp_ei, exp_sq;
    int          pulses;
    logic [5:0]  pulse_mask;

    function automatic logic [53:0] mk(input logic [31:0] g, input logic rst, input logic tx,
                                       input logic rx, input logic [1:0] ph, input logic run,
                                       input logic rd, input logic [14:0] addr);
        return {g, rst, tx, rx, ph, run, rd, addr};
    endfunction

    function automatic logic [63:0] f_samp_q(input logic [63:0] c); return c + 64'd1; endfunction
    function automatic logic [63:0] f_err_i(input logic [63:0] c);  return c + 64'd3; endfunction

    task automatic set_cnts();
        samp_i = cnt_val;
        samp_q = f_samp_q(cnt_val);
        err_i  = f_err_i(cnt_val);
        err_q  = cnt_val + 64'd5;
    endtask

    task automatic step();
        @(negedge clk100);
        if (cnt_run) begin
            cnt_val = cnt_val + 64'd1;
            set_cnts();
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Rising edge on enable for one cycle; returns at the sample point after edge k+1.
    task automatic send(input logic [7:0] op, input logic [22:0] pl);
        gpo0 = {op, 1'b1, pl};
        step();
        gpo0 = {op, 1'b0, pl};
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{"reset_clr",  8'd0,   23'd0,       mk(32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 15'h0)};
        tbl[1]  = '{"en_tx",      8'd1,   23'd1,       mk(32'h0,         1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 15'h0)};
        tbl[2]  = '{"en_rx",      8'd2,   23'd1,       mk(32'h0,         1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 15'h0)};
        tbl[3]  = '{"ph_sel2",    8'd3,   23'd2,       mk(32'h0,         1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 15'h0)};
        tbl[4]  = '{"read_mem",   8'd5,   23'd1,       mk(32'h0,         1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 15'h0)};
        tbl[5]  = '{"ber_s_i",    8'd7,   23'd0,       mk(32'hBBBB_0002, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 15'h0)};
        tbl[6]  = '{"ber_h_si",   8'd11,  23'd0,       mk(32'hAAAA_0001, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 15'h0)};
        tbl[7]  = '{"ber_s_q",    8'd8,   23'd0,       mk(32'h3333_4444, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 15'h0)};
        tbl[8]  = '{"ber_h_sq",   8'd11,  23'd0,       mk(32'h1111_2222, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 15'h0)};
        tbl[9]  = '{"ber_e_i",    8'd9,   23'd0,       mk(32'h7777_8888, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 15'h0)};
        tbl[10] = '{"ber_e_q",    8'd10,  23'd0,       mk(32'h0000_0345, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 15'h0)};
        tbl[11] = '{"ber_h_eq",   8'd11,  23'd0,       mk(32'h0000_0012, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 15'h0)};
        tbl[12] = '{"mem_full",   8'd12,  23'd0,       mk(32'h1,         1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 15'h0)};
        tbl[13] = '{"op200",      8'd200, 23'h7FFFFF,  mk(32'h1,         1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 15'h0)};
        tbl[14] = '{"op13",       8'd13,  23'h7FFFFF,  mk(32'h1,         1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 15'h0)};
        tbl[15] = '{"run_mem",    8'd4,   23'd0,       mk(32'h1,         1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 15'h0)};
        tbl[16] = '{"en_tx_off",  8'd1,   23'd0,       mk(32'h1,         1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 15'h0)};
        tbl[17] = '{"ph_sel1",    8'd3,   23'h7FFFF9,  mk(32'h1,         1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 15'h0)};
        tbl[18] = '{"reset_set",  8'd0,   23'd1,       mk(32'h1,         1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 15'h0)};
        tbl[19] = '{"reset_clr2", 8'd0,   23'd0,       mk(32'h1,         1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 15'h0)};

        i_resetn   = 1'b0;
        gpo0       = 32'd0;
        i_mem_full = 1'b1;
        samp_i     = 64'hAAAA_0001_BBBB_0002;
        samp_q     = 64'h1111_2222_3333_4444;
        err_i      = 64'h5555_6666_7777_8888;
        err_q      = 64'h0000_0012_0000_0345;
        repeat (3) step();
        i_resetn = 1'b1;
        repeat (2) step();
        check("reset_state", 64'(dut_outs), 64'(mk(32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 15'h0)));

        for (int i = 0; i < NV; i++) begin
            sb_q.push_back('{tbl[i].name, tbl[i].exp});
            send(tbl[i].op, tbl[i].pl);
            e = sb_q.pop_front();
            check(e.name, 64'(dut_outs), 64'(e.exp));
        end

        // Enable held high with a changing payload executes only once.
        gpo0 = {8'd3, 1'b1, 23'd2};
        step();
        gpo0 = {8'd3, 1'b1, 23'd0};
        repeat (4) step();
        check("hold_single", 64'(o_phase_sel), 64'd2);
        gpo0 = {8'd3, 1'b0, 23'd3};
        step();
        send(8'd3, 23'd3);
        check("ph_sel3", 64'(o_phase_sel), 64'd3);

        // RUN_MEM held high: one pulse, in the cycle after edge k+1.
        gpo0 = {8'd4, 1'b1, 23'd0};
        pulses = 0;
        pulse_mask = 6'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            pulse_mask[i] = o_run_log;
            if (o_run_log) pulses++;
        end
        check("run_pulses", 64'(pulses), 64'd1);
        check("run_timing", 64'(pulse_mask), 64'b000010);
        gpo0 = 32'd0;
        step();

        // ADDR_MEM with a second command queued during WAIT.
        i_mem_full = 1'b0;
        gpo0 = {8'd6, 1'b1, 23'h2F56};
        step();
        gpo0 = {8'd6, 1'b0, 23'h2F56};
        step();
        check("addr_k1", 64'(o_addr_log), 64'h2F56);
        gpo0 = {8'd12, 1'b1, 23'd0};
        step();
        check("wait_k2", 64'(gpi0), 64'h1);
        gpo0 = {8'd12, 1'b0, 23'd0};
        step();
        check("wait_k3", 64'(gpi0), 64'h1);
        step();
        check("capture_k4", 64'(gpi0), 64'h0000_AF0F);
        step();
        check("pending_exec", 64'(gpi0), 64'h0);

        // Reset during WAIT aborts the read.
        i_mem_full = 1'b1;
        send(8'd12, 23'd0);
        gpo0 = {8'd6, 1'b1, 23'h0010};
        step();
        gpo0 = {8'd6, 1'b0, 23'h0010};
        step();
        i_resetn = 1'b0;
        step();
        check("reset_mid", 64'(dut_outs), 64'(mk(32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 15'h0)));
        i_resetn = 1'b1;
        repeat (5) step();
        check("no_capture", 64'(gpi0), 64'h0);

        // Enable already high at reset release fires exactly once.
        i_resetn = 1'b0;
        gpo0 = {8'd1, 1'b1, 23'd1};
        step();
        i_resetn = 1'b1;
        repeat (2) step();
        check("release_fire", 64'(o_enb_tx), 64'd1);
        gpo0 = {8'd1, 1'b1, 23'd0};
        repeat (3) step();
        check("release_once", 64'(o_enb_tx), 64'd1);
        gpo0 = 32'd0;
        step();

        // Running counters: later reads come from the BER_S_I cycle when the snapshot is built in.
        cnt_val = 64'h0000_0007_FFFF_FFF8;
        set_cnts();
        cnt_run = 1'b1;
        sc = cnt_val + 64'd1;
        send(8'd7, 23'd0);
        check("snap_s_i", 64'(gpi0), 64'(sc[31:0]));
        repeat (8) step();
        dl = cnt_val + 64'd1;
`ifdef GPIO_CMD_BER_SNAPSHOT_EN
        exp_ei = f_err_i(sc);
`else
        exp_ei = f_err_i(dl);
`endif
        send(8'd9, 23'd0);
        check("snap_e_i", 64'(gpi0), 64'(exp_ei[31:0]));
        send(8'd11, 23'd0);
        check("snap_h", 64'(gpi0), 64'(exp_ei[63:32]));
        dl = cnt_val + 64'd1;
`ifdef GPIO_CMD_BER_SNAPSHOT_EN
        exp_sq = f_samp_q(sc);
`else
        exp_sq = f_samp_q(dl);
`endif
        send(8'd8, 23'd0);
        check("snap_s_q", 64'(gpi0), 64'(exp_sq[31:0]));
        send(8'd200, 23'h7FFFFF);
        check("snap_op200", 64'(gpi0), 64'(exp_sq[31:0]));
        cnt_run = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
